// File: rtl/wb_uart_if.sv
// wb_uart_if: Wishbone B3 classic bus bundle for the UART slave.
// Signal names follow the slave's view of the bus.
interface wb_uart_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_i,
    input  dat_o, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_i,
    output dat_o, ack
  );
endinterface

// File: rtl/wb_uart.sv
// wb_uart: Wishbone classic slave UART, 8-deep TX FIFO, 8N1 framing.
// Define UART_LOOPBACK_EN to add CTRL.LOOP internal loopback.
module wb_uart #(
  parameter int CLK_DIV_RST = 868,
  parameter int TXF_AW      = 3
) (
  input  logic     wb_clk_i,
  input  logic     wb_rstn_i,
  wb_uart_if.slave wb,
  output logic     uart_txd_o,
  input  logic     uart_rxd_i,
  output logic     uart_int_o
);
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_e;

  localparam int DEPTH = 1 << TXF_AW;

  logic        req, wr, rd, ack_q, irq_q;
  logic        a_data, a_stat, a_ctrl, a_div;
  logic [31:0] dat_q, rdata;
  logic [15:0] div_q, div_w;
  logic [2:0]  ctrl_q;
  logic        rxv, rxovr, ferr, txovf;
  logic [7:0]  rx_byte;
  logic        rd_data, unused_bits;

  logic [7:0]        mem [DEPTH];
  logic [TXF_AW:0]   wp, rp;
  logic              empty, full;
  logic              push, push_ok, pop;
  logic [7:0]        head;

  st_e         tx_st, tx_st_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        tx_line, busy;

  st_e         rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_src, rx_m, rx_s, rx_p;
  logic        rx_load, rx_ferr;

  assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0],
                         wb.dat_i[31:16], wb.sel[3:2]};

  assign req = wb.cyc & wb.stb & ~ack_q;
  assign wr  = req & wb.we;
  assign rd  = req & ~wb.we;

  assign a_data = wb.adr[3:2] == 2'd0;
  assign a_stat = wb.adr[3:2] == 2'd1;
  assign a_ctrl = wb.adr[3:2] == 2'd2;
  assign a_div  = wb.adr[3:2] == 2'd3;

  assign rd_data = rd & a_data;
  assign push    = wr & a_data & wb.sel[0];
  assign push_ok = push & (~full | pop);

  assign div_w = {
    wb.sel[1] ? wb.dat_i[15:8] : div_q[15:8],
    wb.sel[0] ? wb.dat_i[7:0]  : div_q[7:0]
  };

  assign empty = wp == rp;
  assign full  = (wp[TXF_AW] != rp[TXF_AW]) &&
                 (wp[TXF_AW-1:0] == rp[TXF_AW-1:0]);
  assign head  = mem[rp[TXF_AW-1:0]];
  assign busy  = tx_st != S_IDLE;

  assign wb.ack     = ack_q;
  assign wb.dat_o   = dat_q;
  assign uart_int_o = irq_q;

`ifdef UART_LOOPBACK_EN
  assign rx_src     = ctrl_q[2] ? tx_line : uart_rxd_i;
  assign uart_txd_o = ctrl_q[2] | tx_line;
`else
  assign rx_src     = uart_rxd_i;
  assign uart_txd_o = tx_line;
`endif

  // Read-data select for the addressed register.
  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      a_data: rdata = {24'd0, rx_byte};
      a_stat: rdata = {25'd0, txovf, ferr, rxovr,
                       busy, full, empty, rxv};
      a_ctrl: rdata = {29'd0, ctrl_q};
      a_div:  rdata = {16'd0, div_q};
    endcase
  end

  // Bus response, registers, sticky flags and interrupt.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      div_q   <= 16'(CLK_DIV_RST);
      ctrl_q  <= 3'd0;
      rxv     <= 1'b0;
      rxovr   <= 1'b0;
      ferr    <= 1'b0;
      txovf   <= 1'b0;
      rx_byte <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : 32'd0;
      if (wr && a_div && |wb.sel[1:0])
        div_q <= (div_w < 16'd4) ? 16'd4 : div_w;
      if (wr && a_ctrl && wb.sel[0]) begin
`ifdef UART_LOOPBACK_EN
        ctrl_q <= wb.dat_i[2:0];
`else
        ctrl_q <= {1'b0, wb.dat_i[1:0]};
`endif
      end
      if (wr && a_stat && wb.sel[0]) begin
        if (wb.dat_i[4]) rxovr <= 1'b0;
        if (wb.dat_i[5]) ferr  <= 1'b0;
        if (wb.dat_i[6]) txovf <= 1'b0;
      end
      if (rx_load && rxv && !rd_data) rxovr <= 1'b1;
      if (rx_ferr) ferr <= 1'b1;
      if (push && full && !pop) txovf <= 1'b1;
      if (rd_data) rxv <= 1'b0;
      if (rx_load) rxv <= 1'b1;
      if (rx_load && (!rxv || rd_data))
        rx_byte <= rx_sh;
      irq_q <= (rxv & ctrl_q[0]) |
               (empty & ~busy & ctrl_q[1]);
    end
  end

  // TX FIFO storage; contents need no reset.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wp[TXF_AW-1:0]] <= wb.dat_i[7:0];
  end

  // TX FIFO pointers.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
    end
  end

  // TX state register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      tx_st  <= S_IDLE;
      tx_cnt <= 16'd0;
      tx_bit <= 3'd0;
      tx_sh  <= 8'd0;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
    end
  end

  // TX next state; divisor is re-read at every bit boundary.
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt - 16'd1;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    pop      = 1'b0;
    tx_line  = 1'b1;
    unique case (tx_st)
      S_IDLE: begin
        tx_cnt_n = tx_cnt;
        if (!empty) begin
          pop      = 1'b1;
          tx_sh_n  = head;
          tx_cnt_n = div_q - 16'd1;
          tx_st_n  = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = div_q - 16'd1;
          tx_bit_n = 3'd0;
          tx_st_n  = S_DATA;
        end
      end
      S_DATA: begin
        tx_line = tx_sh[0];
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = div_q - 16'd1;
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_st_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt == 16'd0) begin
          tx_st_n = S_IDLE;
          if (!empty) begin
            pop      = 1'b1;
            tx_sh_n  = head;
            tx_cnt_n = div_q - 16'd1;
            tx_st_n  = S_START;
          end
        end
      end
    endcase
  end

  // RX two-flop synchronizer plus edge-detect history.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_src;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  // RX state register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rx_st  <= S_IDLE;
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
      rx_sh  <= 8'd0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  // RX next state: mid-bit sampling from the start edge.
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt - 16'd1;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_load  = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        rx_cnt_n = rx_cnt;
        if (rx_p && !rx_s) begin
          rx_cnt_n = {1'b0, div_q[15:1]} - 16'd1;
          rx_st_n  = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_n = div_q - 16'd1;
          rx_bit_n = 3'd0;
          rx_st_n  = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_n = div_q - 16'd1;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_load = rx_s;
          rx_ferr = ~rx_s;
          rx_st_n = S_IDLE;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: randomized self-checking bench for wb_uart.
// Serial encoder/decoder and FIFO acceptance model live in the bench.
module tb_wb_uart;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rxd = 1'b1;
  logic txd, irq;
  int   total = 0;
  int   bad = 0;
  int   div_m = 868;
  int   cyc_n = 0;
  logic [7:0] tx_got[$];
  logic       tx_stp[$];
  int         tx_t[$];

  wb_uart_if bus();

  wb_uart dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rstn),
    .wb        (bus),
    .uart_txd_o(txd),
    .uart_rxd_i(rxd),
    .uart_int_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w,
                      input logic [3:0] a,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      output logic [31:0] q);
    int n;
    n = 0;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = w;
    bus.adr = {28'd0, a};
    bus.sel = s;
    bus.dat_i = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.ack !== 1'b1 && n < 16);
    if (bus.ack !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
    q = bus.dat_o;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    xfer(1'b1, a, 4'hF, d, q);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] q;
    xfer(1'b0, a, 4'hF, 32'd0, q);
    chk(tag, q, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    rxd = 1'b0;
    idle(div_m);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(div_m);
    end
    rxd = stp;
    idle(div_m);
    rxd = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c;
    c = 0;
    while (tx_got.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("tx_frames", tx_got.size(), n);
  endtask

  task automatic clr_tx();
    tx_got.delete();
    tx_stp.delete();
    tx_t.delete();
  endtask

  // Serial decoder: mid-bit sampling at the bench's divisor.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && txd === 1'b0) begin
        tx_t.push_back(cyc_n);
        repeat (div_m + div_m / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = txd;
          repeat (div_m) @(negedge clk);
        end
        tx_got.push_back(b);
        tx_stp.push_back(txd);
      end
      prev = txd;
    end
  end

  initial begin : main
    logic [31:0] q;
    logic [3:0]  pat, dpat;
    logic [7:0]  r1, r2, tb;
    logic [7:0]  exp_q[$];
    int          nq, ndrop, dv;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    bus.adr = 32'd0;
    bus.sel = 4'd0;
    bus.dat_i = 32'd0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_int", irq, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_dat", bus.dat_o, 0);
    rstn = 1'b1;
    idle(1);
    rd_chk("rst_status", 4'h4, 32'h2);
    rd_chk("rst_div", 4'hC, 32'd868);
    rd_chk("rst_ctrl", 4'h8, 32'd0);
    rd_chk("rst_data", 4'h0, 32'd0);

    // held request: one ack every other cycle, data only with ack
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = 1'b0;
    bus.adr = 32'h4;
    bus.sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[3-i] = bus.ack;
      dpat[3-i] = (bus.dat_o != 32'd0);
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    idle(1);
    chk("ack_pulse", pat, 4'b1010);
    chk("dat_gate", dpat, 4'b1010);

    xfer(1'b1, 4'hC, 4'h0, 32'd5, q);
    xfer(1'b1, 4'h8, 4'h0, 32'd3, q);
    xfer(1'b1, 4'h0, 4'h0, 32'h55, q);
    rd_chk("sel0_div", 4'hC, 32'd868);
    rd_chk("sel0_ctrl", 4'h8, 32'd0);
    rd_chk("sel0_status", 4'h4, 32'h2);

    wr(4'hC, 32'd2);
    rd_chk("div_clamp", 4'hC, 32'd4);
    xfer(1'b1, 4'hC, 4'b0001, 32'h1234, q);
    rd_chk("div_lane0", 4'hC, 32'h0034);
    xfer(1'b1, 4'hC, 4'b0010, 32'hAB00, q);
    rd_chk("div_lane1", 4'hC, 32'hAB34);
    wr(4'hC, 32'd16);
    div_m = 16;
    idle(4);
    chk("sel0_nopush", tx_got.size(), 0);

    clr_tx();
    wr(4'h0, 32'hA5);
    rd_chk("tx_busy", 4'h4, 32'h0A);
    wait_tx(1, 400);
    chk("tx_a5", tx_got[0], 8'hA5);
    chk("tx_a5_stop", tx_stp[0], 1);
    idle(div_m);
    rd_chk("tx_done", 4'h4, 32'h02);

    for (int k = 0; k < 3; k++) begin
      dv = $urandom_range(5, 24);
      wr(4'hC, dv);
      div_m = dv;
      tb = 8'($urandom);
      clr_tx();
      wr(4'h0, {24'd0, tb});
      wait_tx(1, 12 * dv + 50);
      chk("tx_rand", tx_got[0], tb);
      chk("tx_rand_stop", tx_stp[0], 1);
      idle(dv + 2);
    end

    // overflow/streaming: first byte goes straight to the shifter
    wr(4'hC, 32'd40);
    div_m = 40;
    clr_tx();
    exp_q.delete();
    nq = 0;
    ndrop = 0;
    for (int i = 0; i < 10; i++) begin
      tb = 8'($urandom);
      wr(4'h0, {24'd0, tb});
      if (i == 0) exp_q.push_back(tb);
      else if (nq < 8) begin
        exp_q.push_back(tb);
        nq++;
      end else ndrop++;
      rd_chk("stream_status", 4'h4,
             {25'd0, ndrop > 0, 2'b00, 1'b1,
              nq == 8, nq == 0, 1'b0});
    end
    wait_tx(exp_q.size(), 9 * 400 + 800);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("stream_byte", tx_got[i], exp_q[i]);
      chk("stream_stop", tx_stp[i], 1);
      if (i > 0)
        chk("stream_gap", tx_t[i] - tx_t[i-1], 400);
    end
    idle(div_m + 2);
    rd_chk("ovf_sticky", 4'h4, 32'h42);
    xfer(1'b1, 4'h4, 4'h1, 32'h40, q);
    rd_chk("ovf_clear", 4'h4, 32'h02);

    wr(4'hC, 32'd16);
    div_m = 16;
    wr(4'h8, 32'd1);
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    send_rx(r1, 1'b1);
    idle(2);
    rd_chk("rx_status", 4'h4, 32'h03);
    chk("rx_int", irq, 1);
    rd_chk("rx_data", 4'h0, {24'd0, r1});
    idle(2);
    chk("rx_int_clr", irq, 0);
    rd_chk("rx_rxv_clr", 4'h4, 32'h02);

    send_rx(r1, 1'b1);
    send_rx(r2, 1'b1);
    idle(2);
    rd_chk("rxovr_status", 4'h4, 32'h13);
    rd_chk("rxovr_data", 4'h0, {24'd0, r1});
    rd_chk("rxovr_after", 4'h4, 32'h12);
    xfer(1'b1, 4'h4, 4'h1, 32'h10, q);
    rd_chk("rxovr_clear", 4'h4, 32'h02);

    send_rx(r2, 1'b1);
    send_rx(r1, 1'b0);
    idle(2);
    rd_chk("ferr_status", 4'h4, 32'h23);
    rd_chk("ferr_data", 4'h0, {24'd0, r2});
    xfer(1'b1, 4'h4, 4'h1, 32'h20, q);
    rd_chk("ferr_clear", 4'h4, 32'h02);

    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(200);
    rd_chk("glitch", 4'h4, 32'h02);
    chk("glitch_int", irq, 0);

    wr(4'h8, 32'd2);
    idle(2);
    chk("txint_idle", irq, 1);
    clr_tx();
    tb = 8'($urandom);
    wr(4'h0, {24'd0, tb});
    idle(2);
    chk("txint_busy", irq, 0);
    wait_tx(1, 400);
    chk("txint_byte", tx_got[0], tb);
    idle(div_m + 2);
    chk("txint_done", irq, 1);
    wr(4'h8, 32'd0);
    idle(2);
    chk("txint_off", irq, 0);

`ifdef UART_LOOPBACK_EN
    wr(4'h8, 32'd4);
    clr_tx();
    tb = 8'($urandom);
    wr(4'h0, {24'd0, tb});
    idle(12 * div_m);
    chk("lb_quiet", tx_got.size(), 0);
    rd_chk("lb_status", 4'h4, 32'h03);
    rd_chk("lb_data", 4'h0, {24'd0, tb});
    wr(4'h8, 32'd0);
`else
    wr(4'h8, 32'd7);
    rd_chk("ctrl_noloop", 4'h8, 32'd3);
    wr(4'h8, 32'd0);
`endif

    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    idle(30);
    chk("pre_rst_txd", txd, 0);
    rstn = 1'b0;
    #1;
    chk("rst_mid_txd", txd, 1);
    idle(2);
    rstn = 1'b1;
    idle(1);
    rd_chk("rst_mid_status", 4'h4, 32'h02);
    rd_chk("rst_mid_div", 4'hC, 32'd868);
    idle(50);
    chk("rst_mid_quiet", txd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
